adjacency_responder: RTL and testbench

Graph-memory responder for the path-counting core. It stores the node/edge adjacency tables and the per-part start/end node pairs. During a run it answers the core's node fetch requests by streaming that node's successor indices, one per cycle, each with a countdown counter. It sits between the host load port and the core's `node_idx_reg` / `rd_next_node_reg` → `next_node_idx` / `next_node_counter` interface.

---
 rtl/adjacency_responder.sv | 190 +++++++++++++++++++
 tb/tb_adjacency_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/adjacency_responder.sv
// adjacency_responder
// Graph-memory responder for the path-counting core. Holds the node table
// ({base, degree}), the edge table (successor indices) and the per-part
// start/end endpoint pairs. During a run it emits the selected start and end
// nodes, then for every node the core fetches it streams that node's
// successors one per cycle, each tagged with a countdown (1 = last edge).
//
// Optional feature: define ADJ_RESPONDER_BOUNDS_CHECK_EN to flag FETCH
// requests whose edge range runs past the end of the edge table, or whose
// node index is NULL. Without it, edge addresses silently wrap.
module adjacency_responder #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_COUNTER_WIDTH   = 5,
    parameter int PARAM_EDGE_ADDR_WIDTH = 12,
    parameter int PARAM_LOAD_DATA_WIDTH = 32,
    localparam int LOAD_ADDR_WIDTH =
        (PARAM_NODE_IDX_WIDTH > PARAM_EDGE_ADDR_WIDTH) ? PARAM_NODE_IDX_WIDTH
                                                       : PARAM_EDGE_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load_valid,
    input  logic [1:0]                       load_sel,
    input  logic [LOAD_ADDR_WIDTH-1:0]       load_addr,
    input  logic [PARAM_LOAD_DATA_WIDTH-1:0] load_data,
    output logic                             graph_ready,
    input  logic                             part_sel,
    input  logic                             start_run,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx,
    input  logic                             rd_next_node,
    input  logic                             done,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
    output logic                             err
);

    localparam int NW = PARAM_NODE_IDX_WIDTH;
    localparam int CW = PARAM_COUNTER_WIDTH;
    localparam int EW = PARAM_EDGE_ADDR_WIDTH;

    localparam logic [NW-1:0] NULL_IDX = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_START,
        SEND_END,
        FETCH,
        STREAM,
        DONE
    } state_t;

    state_t state;

    // Tables: node entry is {base, degree}, degree in the LSBs
    logic [EW+CW-1:0] node_mem [2**NW];
    logic [NW-1:0]    edge_mem [2**EW];

    logic [1:0][NW-1:0] start_pt;
    logic [1:0][NW-1:0] end_pt;
    logic               part;
    logic [EW-1:0]      cursor;

    logic               load_ok;
    logic [EW-1:0]      node_base;
    logic [CW-1:0]      node_degree;
    logic               fetch_range_err;
    logic               unused_load_bits;

    // Loads are only legal while parked in IDLE with the run disabled
    assign load_ok = load_valid && (state == IDLE) && !start_run;

    // Single-cycle asynchronous lookup of the requested node's entry
    assign {node_base, node_degree} = node_mem[node_idx];

    // Not every load bit reaches a table for every parameter set
    assign unused_load_bits = ^{load_data, load_addr};

`ifdef ADJ_RESPONDER_BOUNDS_CHECK_EN
    // Flag edge ranges running past the table end and NULL node requests
    always_comb begin
        fetch_range_err = (node_idx == NULL_IDX) ||
                          ((int'(node_base) + int'(node_degree)) > (2 ** EW));
    end
`else
    assign fetch_range_err = 1'b0;
`endif

    // Table writes; arrays are intentionally left unreset (reload after rst)
    always_ff @(posedge clk) begin
        if (!rst && load_ok) begin
            if (load_sel == 2'd0) begin
                node_mem[load_addr[NW-1:0]] <= load_data[EW+CW-1:0];
            end
            if (load_sel == 2'd1) begin
                edge_mem[load_addr[EW-1:0]] <= load_data[NW-1:0];
            end
        end
    end

    // Load control, run sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            next_node_idx     <= '0;
            next_node_counter <= '0;
            graph_ready       <= 1'b0;
            err               <= 1'b0;
            start_pt          <= '0;
            end_pt            <= '0;
            part              <= 1'b0;
            cursor            <= '0;
        end else begin
            if (load_valid && !load_ok) begin
                err <= 1'b1;
            end
            if (load_ok) begin
                // load_done marks the tables valid; any table write invalidates them
                graph_ready <= (load_sel == 2'd3);
                if (load_sel == 2'd2) begin
                    start_pt[load_addr[0]] <= load_data[NW-1:0];
                    end_pt[load_addr[0]]   <= load_data[2*NW-1:NW];
                end
            end

            if (start_run) begin
                if (done && (state != IDLE) && (state != DONE)) begin
                    // done overrides whatever the running state would do
                    state             <= DONE;
                    next_node_idx     <= '0;
                    next_node_counter <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (graph_ready) begin
                                part              <= part_sel;
                                next_node_idx     <= start_pt[part_sel];
                                next_node_counter <= CNT_ONE;
                                state             <= SEND_START;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                        SEND_START: begin
                            next_node_idx     <= end_pt[part];
                            next_node_counter <= CNT_ONE;
                            state             <= SEND_END;
                        end
                        SEND_END: begin
                            state <= FETCH;
                        end
                        FETCH: begin
                            if (!rd_next_node || fetch_range_err) begin
                                err <= 1'b1;
                            end
                            state <= STREAM;
                            if (node_degree == '0) begin
                                // Leaf request: answer NULL as a single final edge
                                next_node_idx     <= NULL_IDX;
                                next_node_counter <= CNT_ONE;
                                err               <= 1'b1;
                            end else begin
                                next_node_idx     <= edge_mem[node_base];
                                next_node_counter <= node_degree;
                                cursor            <= node_base + EW'(1);
                            end
                        end
                        STREAM: begin
                            if (next_node_counter > CNT_ONE) begin
                                next_node_idx     <= edge_mem[cursor];
                                next_node_counter <= next_node_counter - CNT_ONE;
                                cursor            <= cursor + EW'(1);
                            end else begin
                                state <= FETCH;
                            end
                        end
                        DONE: begin
                            next_node_idx     <= '0;
                            next_node_counter <= '0;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_adjacency_responder.sv
// tb_adjacency_responder
// Directed bench for adjacency_responder: expected outputs are queued when a
// cycle is driven and checked just after the corresponding clock edge.
module tb_adjacency_responder;

    typedef struct {
        string      tag;
        logic [9:0] idx;
        logic [4:0] cnt;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [1:0]  load_sel;
    logic [11:0] load_addr;
    logic [31:0] load_data;
    logic        graph_ready;
    logic        part_sel;
    logic        start_run;
    logic [9:0]  node_idx;
    logic        rd_next_node;
    logic        done;
    logic [9:0]  next_node_idx;
    logic [4:0]  next_node_counter;
    logic        err;

    int   checks;
    int   errors;
    exp_t sb[$];

    adjacency_responder #(
        .PARAM_NODE_IDX_WIDTH  (10),
        .PARAM_COUNTER_WIDTH   (5),
        .PARAM_EDGE_ADDR_WIDTH (12),
        .PARAM_LOAD_DATA_WIDTH (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_sel          (load_sel),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .graph_ready       (graph_ready),
        .part_sel          (part_sel),
        .start_run         (start_run),
        .node_idx          (node_idx),
        .rd_next_node      (rd_next_node),
        .done              (done),
        .next_node_idx     (next_node_idx),
        .next_node_counter (next_node_counter),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue the expected outputs, advance one edge, then compare
    task automatic step(input string tag, input int idx, input int cnt, input logic e);
        exp_t x;
        exp_t got;
        x.tag = tag;
        x.idx = 10'(idx);
        x.cnt = 5'(cnt);
        x.err = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".idx"}, 32'(next_node_idx), 32'(got.idx));
        chk({got.tag, ".cnt"}, 32'(next_node_counter), 32'(got.cnt));
        chk({got.tag, ".err"}, 32'(err), 32'(got.err));
    endtask

    task automatic load(input logic [1:0] sel, input int addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = 12'(addr);
        load_data  = data;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic load_all();
        load(2'd2, 0, (32'd9 << 10) | 32'd3);   // part0 {end=9, start=3}
        load(2'd2, 1, (32'd2 << 10) | 32'd7);   // part1 {end=2, start=7}
        load(2'd0, 3, (32'd0 << 5) | 32'd2);    // node3 base0 deg2
        load(2'd0, 5, (32'd2 << 5) | 32'd1);    // node5 base2 deg1
        load(2'd0, 9, (32'd3 << 5) | 32'd3);    // node9 base3 deg3
        load(2'd0, 7, (32'd10 << 5) | 32'd0);   // node7 deg0
        load(2'd1, 0, 32'd5);
        load(2'd1, 1, 32'd9);
        load(2'd1, 2, 32'd9);
        load(2'd1, 3, 32'd5);
        load(2'd1, 4, 32'd3);
        load(2'd1, 5, 32'd7);
        load(2'd3, 0, 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        load_valid   = 1'b0;
        load_sel     = 2'd0;
        load_addr    = '0;
        load_data    = '0;
        part_sel     = 1'b0;
        start_run    = 1'b0;
        node_idx     = '0;
        rd_next_node = 1'b0;
        done         = 1'b0;

        step("reset", 0, 0, 1'b0);
        chk("reset.ready", 32'(graph_ready), 32'd0);
        rst = 1'b0;

        load_all();
        chk("load_done.ready", 32'(graph_ready), 32'd1);
        load(2'd1, 0, 32'd5);
        chk("rewrite.ready", 32'(graph_ready), 32'd0);
        load(2'd3, 0, 32'd0);
        chk("reload_done.ready", 32'(graph_ready), 32'd1);

        // Part 0 run: start, end, node3 stream, node5 stream, node9 with pause
        part_sel  = 1'b0;
        start_run = 1'b1;
        step("r0.c1", 3, 1, 1'b0);
        step("r0.c2", 9, 1, 1'b0);
        node_idx     = 10'd3;
        rd_next_node = 1'b1;
        step("r0.c3", 9, 1, 1'b0);
        step("r0.c4", 5, 2, 1'b0);
        step("r0.c5", 9, 1, 1'b0);
        node_idx = 10'd5;
        step("r0.c6", 9, 1, 1'b0);
        step("r0.c7", 9, 1, 1'b0);
        node_idx = 10'd9;
        step("r0.c8", 9, 1, 1'b0);
        step("r0.c9", 5, 3, 1'b0);
        start_run = 1'b0;
        step("pause1", 5, 3, 1'b0);
        load_valid = 1'b1;
        load_sel   = 2'd1;
        load_addr  = 12'd4;
        load_data  = 32'd0;
        step("pause2", 5, 3, 1'b1);
        load_valid = 1'b0;
        step("pause3", 5, 3, 1'b1);
        start_run = 1'b1;
        step("resume1", 3, 2, 1'b1);
        step("resume2", 7, 1, 1'b1);
        step("fetch_gap", 7, 1, 1'b1);
        done = 1'b1;
        step("done", 0, 0, 1'b1);
        done = 1'b0;
        step("done_hold", 0, 0, 1'b1);

        // Reset mid-STREAM, then a start without reload
        rst       = 1'b1;
        start_run = 1'b0;
        step("rst_done", 0, 0, 1'b0);
        rst = 1'b0;
        load_all();
        part_sel  = 1'b0;
        start_run = 1'b1;
        node_idx  = 10'd3;
        step("r1.c1", 3, 1, 1'b0);
        step("r1.c2", 9, 1, 1'b0);
        step("r1.c3", 9, 1, 1'b0);
        step("r1.c4", 5, 2, 1'b0);
        rst = 1'b1;
        step("rst_stream", 0, 0, 1'b0);
        chk("rst_stream.ready", 32'(graph_ready), 32'd0);
        rst = 1'b0;
        step("noload1", 0, 0, 1'b1);
        step("noload2", 0, 0, 1'b1);
        start_run = 1'b0;

        // Part 1 run: endpoints from part1, node7 has degree 0, done on last edge
        rst = 1'b1;
        step("rst2", 0, 0, 1'b0);
        rst = 1'b0;
        load_all();
        part_sel  = 1'b1;
        start_run = 1'b1;
        node_idx  = 10'd7;
        step("p1.c1", 7, 1, 1'b0);
        part_sel = 1'b0;
        step("p1.c2", 2, 1, 1'b0);
        step("p1.c3", 2, 1, 1'b0);
        step("p1.deg0", 1023, 1, 1'b1);
        done = 1'b1;
        step("p1.done_last", 0, 0, 1'b1);
        done      = 1'b0;
        start_run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
